// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS.hh stopwatch/timer.
// BLANK is the code the seven-segment driver renders as an unlit digit.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BLANK     = 4'hF;
  localparam bcd_t DIG_MAX_9 = 4'd9;
  localparam bcd_t DIG_MAX_5 = 4'd5;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    bcd_t hund_tens;
    bcd_t hund_ones;
  } disp_t;

  function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t dmax);
    return (d > dmax) ? dmax : d;
  endfunction

endpackage

// File: rtl/stopwatch_lap_bcd_digit.sv
// One BCD digit counting 0..DMAX in either direction, with load and
// a terminal-count output that enables the next digit up the cascade.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned DMAX = 9
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic load,
  input  bcd_t load_val,
  input  logic up,
  input  logic en_in,
  output bcd_t value,
  output bcd_t value_nxt,
  output logic tc
);

  localparam bcd_t DMAX_B = bcd_t'(DMAX);

  // value_nxt is exported so the parent can snapshot the post-edge count
  always_comb begin
    value_nxt = value;
    if (!nrst || clear)
      value_nxt = '0;
    else if (load)
      value_nxt = load_val;
    else if (en_in) begin
      if (up)
        value_nxt = (value == DMAX_B) ? '0 : value + 4'd1;
      else
        value_nxt = (value == '0) ? DMAX_B : value - 4'd1;
    end
  end

  assign tc = en_in && (up ? (value == DMAX_B) : (value == '0));

  always_ff @(posedge clk) begin
    value <= value_nxt;
  end

endmodule

// File: rtl/stopwatch_lap.sv
// Six-digit BCD stopwatch / countdown timer with prescaler, preset load,
// lap freeze and status flags; drives the seven-segment digit inputs.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV = 10,
  parameter int unsigned MAX_MIN = 59
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  input  logic        ena,
  input  logic        oen,
  input  logic        dir,
  input  logic        load,
  input  logic [23:0] preset,
  input  logic        lap,
  output bcd_t        min_tens,
  output bcd_t        min_ones,
  output bcd_t        sec_tens,
  output bcd_t        sec_ones,
  output bcd_t        hund_tens,
  output bcd_t        hund_ones,
  output logic        tick,
  output logic        wrap,
  output logic        done,
  output logic        frozen
);

  localparam int unsigned PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_DIV - 1);
  localparam bcd_t MAX_MIN_T = bcd_t'(MAX_MIN / 10);
  localparam bcd_t MAX_MIN_O = bcd_t'(MAX_MIN % 10);

  logic [PW-1:0] presc;
  logic [23:0]   cnt, cnt_nxt, ld_val;
  logic [5:0]    en, tc;
  logic [7:0]    ld_min;
  bcd_t          ld_mo;
  disp_t         snap, shown;
  logic          lap_q, lap_rise, adv, adv_cnt, roll, cnt_zero, at_max, clr_d;

  // Minutes are clamped on their combined BCD value, not per digit
  always_comb begin
    ld_mo         = clamp_digit(preset[19:16], DIG_MAX_9);
    ld_min        = 8'(preset[23:20]) * 8'd10 + 8'(ld_mo);
    ld_val[3:0]   = clamp_digit(preset[3:0],   DIG_MAX_9);
    ld_val[7:4]   = clamp_digit(preset[7:4],   DIG_MAX_9);
    ld_val[11:8]  = clamp_digit(preset[11:8],  DIG_MAX_9);
    ld_val[15:12] = clamp_digit(preset[15:12], DIG_MAX_5);
    if (ld_min > 8'(MAX_MIN))
      ld_val[23:16] = {MAX_MIN_T, MAX_MIN_O};
    else
      ld_val[23:16] = {preset[23:20], ld_mo};
  end

  assign cnt_zero = (cnt == '0);
  assign at_max   = (cnt == {MAX_MIN_T, MAX_MIN_O, 16'h5999});
  assign adv      = ena && !done && (presc == PRESC_TC) && !clear && !load;
  assign adv_cnt  = adv && !(dir && cnt_zero);
  // tc[5] only fires at 99:59.99, which is at_max whenever it is reachable
  assign roll     = !dir && ((adv_cnt && at_max) || tc[5]);
  assign clr_d    = clear || roll;
  assign lap_rise = lap && !lap_q;

  assign en[0] = adv_cnt;
  assign en[5:1] = tc[4:0];

  for (genvar i = 0; i < 6; i++) begin : g_dig
    bcd_digit #(.DMAX((i == 3) ? 5 : 9)) u_dig (
      .clk       (clk),
      .nrst      (nrst),
      .clear     (clr_d),
      .load      (load),
      .load_val  (ld_val[4*i +: 4]),
      .up        (!dir),
      .en_in     (en[i]),
      .value     (cnt[4*i +: 4]),
      .value_nxt (cnt_nxt[4*i +: 4]),
      .tc        (tc[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      presc  <= '0;
      done   <= 1'b0;
      frozen <= 1'b0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
      lap_q  <= 1'b0;
      snap   <= '0;
    end else begin
      lap_q <= lap;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      if (clear || load) begin
        presc  <= '0;
        done   <= 1'b0;
        frozen <= 1'b0;
      end else begin
        if (ena && !done)
          presc <= (presc == PRESC_TC) ? '0 : presc + PW'(1);
        tick <= adv_cnt;
        wrap <= roll;
        if (adv && dir && (cnt_nxt == '0))
          done <= 1'b1;
        if (lap_rise) begin
          frozen <= !frozen;
          if (!frozen)
            snap <= cnt_nxt;
        end
      end
    end
  end

  assign shown     = frozen ? snap : disp_t'(cnt);
  assign min_tens  = oen ? shown.min_tens  : BLANK;
  assign min_ones  = oen ? shown.min_ones  : BLANK;
  assign sec_tens  = oen ? shown.sec_tens  : BLANK;
  assign sec_ones  = oen ? shown.sec_ones  : BLANK;
  assign hund_tens = oen ? shown.hund_tens : BLANK;
  assign hund_ones = oen ? shown.hund_ones : BLANK;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap: a MAX_MIN=59 unit and a MAX_MIN=2 unit
// share all inputs; expected values are hand-computed constants.
module tb_stopwatch_lap;
  import stopwatch_pkg::*;

  logic        clk = 1'b0;
  logic        nrst, clear, ena, oen, dir, load, lap;
  logic [23:0] preset;

  bcd_t mt1, mo1, st1, so1, ht1, ho1;
  bcd_t mt2, mo2, st2, so2, ht2, ho2;
  logic tick1, wrap1, done1, frozen1;
  logic tick2, wrap2, done2, frozen2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ticks;

  always #5 clk = ~clk;

  stopwatch_lap #(.CLK_DIV(10), .MAX_MIN(59)) u_dut (
    .clk(clk), .nrst(nrst), .clear(clear), .ena(ena), .oen(oen), .dir(dir),
    .load(load), .preset(preset), .lap(lap),
    .min_tens(mt1), .min_ones(mo1), .sec_tens(st1), .sec_ones(so1),
    .hund_tens(ht1), .hund_ones(ho1),
    .tick(tick1), .wrap(wrap1), .done(done1), .frozen(frozen1)
  );

  stopwatch_lap #(.CLK_DIV(10), .MAX_MIN(2)) u_dut2 (
    .clk(clk), .nrst(nrst), .clear(clear), .ena(ena), .oen(oen), .dir(dir),
    .load(load), .preset(preset), .lap(lap),
    .min_tens(mt2), .min_ones(mo2), .sec_tens(st2), .sec_ones(so2),
    .hund_tens(ht2), .hund_ones(ho2),
    .tick(tick2), .wrap(wrap2), .done(done2), .frozen(frozen2)
  );

  wire [23:0] dig1 = {mt1, mo1, st1, so1, ht1, ho1};
  wire [23:0] dig2 = {mt2, mo2, st2, so2, ht2, ho2};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0; clear = 1'b0; ena = 1'b0; oen = 1'b1; dir = 1'b0;
    load = 1'b0; lap = 1'b0; preset = '0;
    step(2);
    check_val("reset_digits", dig1, 24'h000000);
    check_val("reset_flags", {tick1, wrap1, done1, frozen1}, 4'b0000);

    // free-running up count
    nrst = 1'b1; ena = 1'b1;
    step(9);
    check_val("pre_first_adv", dig1, 24'h000000);
    check_val("pre_first_tick", tick1, 1'b0);
    step(1);
    check_val("first_adv", dig1, 24'h000001);
    check_val("first_tick", tick1, 1'b1);
    step(1);
    check_val("tick_one_cycle", tick1, 1'b0);
    step(9);
    check_val("second_adv", dig1, 24'h000002);
    check_val("second_tick", tick1, 1'b1);
    check_val("up_no_done", done1, 1'b0);

    // clear lands on an advance edge
    step(9);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_val("clear_digits", dig1, 24'h000000);
    check_val("clear_no_tick", tick1, 1'b0);

    // oen blanking while counting continues
    oen = 1'b0;
    step(10);
    check_val("oen_blank", dig1, 24'hFFFFFF);
    oen = 1'b1;
    #1;
    check_val("oen_restore", dig1, 24'h000001);

    // up rollover on the MAX_MIN=2 unit, sec->min carry on the other
    preset = 24'h025999; load = 1'b1;
    step(1);
    load = 1'b0;
    check_val("load_max2", dig2, 24'h025999);
    step(9);
    check_val("pre_wrap", wrap2, 1'b0);
    step(1);
    check_val("wrap_digits", dig2, 24'h000000);
    check_val("wrap_pulse", wrap2, 1'b1);
    check_val("carry_to_min", dig1, 24'h030000);
    check_val("no_wrap_max59", wrap1, 1'b0);
    step(1);
    check_val("wrap_one_cycle", wrap2, 1'b0);

    // countdown to done
    preset = 24'h000003; dir = 1'b1; load = 1'b1;
    step(1);
    load = 1'b0;
    check_val("cd_load", dig1, 24'h000003);
    step(10);
    check_val("cd_02", dig1, 24'h000002);
    step(10);
    check_val("cd_01", dig1, 24'h000001);
    check_val("cd_01_done", done1, 1'b0);
    step(10);
    check_val("cd_00", dig1, 24'h000000);
    check_val("cd_done_set", done1, 1'b1);
    check_val("cd_done_tick", tick1, 1'b1);
    n_ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (tick1) n_ticks++;
    end
    check_val("cd_no_more_ticks", n_ticks, 0);
    check_val("cd_hold_zero", dig1, 24'h000000);
    check_val("cd_done_sticky", done1, 1'b1);
    preset = 24'h000100; load = 1'b1;
    step(1);
    load = 1'b0;
    check_val("load_clears_done", done1, 1'b0);
    check_val("load_0100", dig1, 24'h000100);
    step(10);
    check_val("cd_borrow", dig1, 24'h000099);

    // load clamping
    preset = 24'h7A6FFF; load = 1'b1;
    step(1);
    load = 1'b0;
    check_val("clamp_max59", dig1, 24'h595999);
    check_val("clamp_max2", dig2, 24'h025999);

    // lap freeze
    dir = 1'b0; clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(50);
    check_val("lap_pre", dig1, 24'h000005);
    ena = 1'b0; lap = 1'b1;
    step(1);
    lap = 1'b0;
    step(2);
    check_val("lap_frozen", frozen1, 1'b1);
    check_val("lap_snap", dig1, 24'h000005);
    ena = 1'b1;
    step(40);
    check_val("lap_hold", dig1, 24'h000005);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    step(1);
    check_val("lap_unfrozen", frozen1, 1'b0);
    check_val("lap_live", dig1, 24'h000009);

    // reset mid-count
    nrst = 1'b0;
    step(1);
    check_val("rst_mid_digits", dig1, 24'h000000);
    check_val("rst_mid_flags", {tick1, wrap1, done1, frozen1}, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
